countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
// - Loadable SIZE-bit down-counter with a start/done/ack handshake.
// - Counterpart of the team's n-bit incrementor: counts down through a mux-based decrementor datapath.
// - Used as a cycle-distance timer: the load value N produces done exactly N cycles after start is accepted.
// PARAMETERS
// - SIZE  8  counter width in bits; must be even (the decrementor is built from 2-bit stages).
// PORTS
// - clk        in   1     rising-edge clock.
// - rst_n      in   1     asynchronous, active-low reset.
// - start      in   1     request a countdown; sampled only in IDLE.
// - loadValue  in   SIZE  start count N; sampled on the same edge as start.
// - pause      in   1     while high in RUN, hold count.
// - abort      in   1     in RUN, return to IDLE without asserting done.
// - ack        in   1     in DONE, acknowledges done and returns to IDLE.
// - count      out  SIZE  current count register.
// - busy       out  1     high while in RUN.
// - done       out  1     high while in DONE; held until ack.
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=IDLE, count=0, busy=0, done=0. Reset takes effect immediately, including mid-RUN.
// - Moore FSM, 2-bit state: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
//   2'b11 is illegal and recovers to IDLE on the next edge.
//   busy=(state==RUN) and done=(state==DONE); both are decoded from the state register, with no combinational input paths.
// - IDLE
//   - start=1: count<=loadValue; next state is DONE if loadValue==0, otherwise RUN.
//   - start=0: hold state and count.
// - RUN (priority: abort > pause > decrement)
//   - abort=1: next state IDLE; count holds its value.
//   - pause=1: hold state and count.
//   - Otherwise: count<=count-1 via the decrementor. If count==1 on that edge, next state is DONE.
// - DONE
//   - count holds 0.
//   - ack=1: next state IDLE.
//   - start is ignored in DONE, including when start and ack arrive in the same cycle.
// - start is ignored in RUN; there is no restart while running.
// - Latency: start accepted at edge 0 loads N.
//   - Edges 1..N decrement; after edge N, state=DONE and done=1.
//   - busy is high for exactly N cycles, plus the number of pause cycles.
//   - N=0: DONE after edge 0; busy never asserts.
// - Arithmetic: count-1 is computed modulo 2^SIZE. The decrementor borrow output is unused by the FSM, because count is never decremented from 0.
// - Maximum run: loadValue=2^SIZE-1 gives 2^SIZE-1 decrement cycles.
// STRUCTURE
// - Shared package/include: state localparams (IDLE, RUN, DONE) and the default SIZE.
// - Sub-module n_bit_decrementor #(SIZE): inputs A; outputs diff and borrowOut.
//   - Composed of SIZE/2 two-bit mux-based half-subtractor stages.
//   - borrow[0]=1'b1; borrowOut=borrow[SIZE/2], which is 1 iff A==0.
//   - Purely combinational.
// - Top: state register, count register, and next-state/next-count logic around one n_bit_decrementor instance.
// TESTING
// - Async reset: drop rst_n mid-RUN at count=8'h03 -> count=0, busy=0, done=0 before the next edge; IDLE after release.
// - Basic countdown, SIZE=8, loadValue=5, one-cycle start:
//   - count goes 5,4,3,2,1,0 on successive edges and busy is high for 5 cycles.
//   - done rises after edge 5 and stays high until ack; after ack, state is IDLE.
// - Zero load: loadValue=0 with start -> done=1 after the load edge; busy stays 0 throughout.
// - Pause: loadValue=6, pause held for 3 cycles while count=3 -> count stays 3 for 3 cycles; done is delayed to edge 9.
// - Full range: loadValue=8'hFF runs 255 decrements with correct borrow across 2-bit stages.
//   - Check 8'h10->8'h0F and 8'h40->8'h3F.
//   - Separate run: abort at count=8'h80 -> IDLE, count holds 8'h80, done never rises.
// - Ignored inputs:
//   - start pulsed in RUN -> no reload.
//   - start and ack together in DONE -> IDLE with count unchanged at 0.
//   - A further start in IDLE loads normally.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

  localparam int DEFAULT_SIZE = 8;

  // 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer_decrementor.sv
// Combinational SIZE-bit decrementor (A - 1) built from 2-bit mux-based
// half-subtractor stages. SIZE must be even.
// borrowOut is high only when A == 0.
module n_bit_decrementor #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] A,
  output logic [SIZE-1:0] diff,
  output logic            borrowOut
);

  localparam int STAGES = SIZE / 2;

  logic [STAGES:0] borrow;

  assign borrow[0] = 1'b1;

  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_stage
    logic lo_borrow;
    // Each bit flips when a borrow reaches it; the borrow ripples on only through a 0 bit.
    assign diff[2*g]     = borrow[g] ? ~A[2*g] : A[2*g];
    assign lo_borrow     = borrow[g] ? ~A[2*g] : 1'b0;
    assign diff[2*g+1]   = lo_borrow ? ~A[2*g+1] : A[2*g+1];
    assign borrow[g+1]   = lo_borrow ? ~A[2*g+1] : 1'b0;
  end

  assign borrowOut = borrow[STAGES];

endmodule : n_bit_decrementor

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/done/ack handshake. Load value N yields
// done exactly N cycles after start is accepted (plus any pause cycles).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for start; count holds
//   RUN     | counting down (abort > pause > decrement)
//   DONE    | count reached 0; done held until ack
//   2'b11   | illegal, returns to IDLE on next edge
import countdown_timer_pkg::*;

module countdown_timer #(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] loadValue,
  input  logic            pause,
  input  logic            abort,
  input  logic            ack,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done
);

  state_e            state_q;
  logic [SIZE-1:0]   count_q;
  logic [SIZE-1:0]   count_dec;
  // Never consumed: RUN is never entered or held with count == 0.
  logic              dec_borrow_unused;

  n_bit_decrementor #(.SIZE(SIZE)) u_dec (
    .A         (count_q),
    .diff      (count_dec),
    .borrowOut (dec_borrow_unused)
  );

  // State and count registers with next-state/next-count logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            count_q <= loadValue;
            state_q <= (loadValue == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (!pause) begin
            count_q <= count_dec;
            if (count_q == SIZE'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer (SIZE = 8).
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] loadValue;
  logic       pause;
  logic       abort;
  logic       ack;
  logic [7:0] count;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;

  countdown_timer #(.SIZE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .loadValue (loadValue),
    .pause     (pause),
    .abort     (abort),
    .ack       (ack),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One active edge, then settle to the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load(input logic [7:0] v);
    loadValue = v;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    loadValue = 8'h00;
    pause     = 1'b0;
    abort     = 1'b0;
    ack       = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Basic countdown from 5
    begin
      int busy_cycles;
      busy_cycles = 0;
      start_load(8'd5);
      check("basic_load", count, 5);
      check("basic_busy0", busy, 1);
      if (busy) busy_cycles++;
      for (int k = 4; k >= 0; k--) begin
        step();
        check("basic_cnt", count, k);
        check("basic_done", done, (k == 0) ? 1 : 0);
        if (busy) busy_cycles++;
      end
      check("basic_busy_cycles", busy_cycles, 5);
      for (int i = 0; i < 3; i++) begin
        step();
        check("basic_done_hold", done, 1);
        check("basic_cnt_hold", count, 0);
      end
      do_ack();
      check("basic_ack_done", done, 0);
      check("basic_ack_busy", busy, 0);
    end

    // Zero load: straight to DONE
    start_load(8'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_cnt", count, 0);
    do_ack();
    check("zero_ack_done", done, 0);
    check("zero_ack_busy", busy, 0);

    // Pause for 3 cycles at count 3; done at edge 9
    start_load(8'd6);
    step(); step(); step();
    check("pause_pre", count, 3);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_hold", count, 3);
      check("pause_busy", busy, 1);
    end
    pause = 1'b0;
    step();
    check("pause_e7", count, 2);
    step();
    check("pause_e8", count, 1);
    check("pause_e8_done", done, 0);
    step();
    check("pause_e9", count, 0);
    check("pause_e9_done", done, 1);
    do_ack();

    // Full range from 8'hFF
    start_load(8'hFF);
    for (int k = 1; k <= 255; k++) begin
      logic [7:0] exp_cnt;
      exp_cnt = 8'(255 - k);
      step();
      check("full_cnt", count, exp_cnt);
      if (exp_cnt == 8'h0F) check("full_10_to_0f", count, 8'h0F);
      if (exp_cnt == 8'h3F) check("full_40_to_3f", count, 8'h3F);
      check("full_done", done, (k == 255) ? 1 : 0);
    end
    do_ack();

    // Abort at 8'h80
    start_load(8'hFF);
    repeat (127) step();
    check("abort_pre", count, 8'h80);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_cnt", count, 8'h80);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", done, 0);
      check("abort_cnt_hold", count, 8'h80);
    end

    // Ignored inputs: start in RUN, start+ack in DONE
    start_load(8'd5);
    step();
    check("ign_cnt4", count, 4);
    loadValue = 8'd9;
    start     = 1'b1;
    step();
    start     = 1'b0;
    check("ign_no_reload", count, 3);
    check("ign_busy", busy, 1);
    step(); step(); step();
    check("ign_done", done, 1);
    loadValue = 8'd7;
    start     = 1'b1;
    ack       = 1'b1;
    step();
    start     = 1'b0;
    ack       = 1'b0;
    check("ign_sa_busy", busy, 0);
    check("ign_sa_done", done, 0);
    check("ign_sa_cnt", count, 0);
    step();
    check("ign_idle_cnt", count, 0);
    check("ign_idle_busy", busy, 0);
    start_load(8'd2);
    check("ign_reload", count, 2);
    check("ign_reload_busy", busy, 1);
    step(); step();
    check("ign_reload_done", done, 1);
    do_ack();

    // Asynchronous reset mid-RUN at count 3
    start_load(8'd5);
    step(); step();
    check("arst_pre", count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt", count, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst_idle_busy", busy, 0);
    check("arst_idle_done", done, 0);
    check("arst_idle_cnt", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_countdown_timer
